mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 64, address width in bits.
REQ-002 Parameter DW, default 64, data width in bits; DW/8 byte strobes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  fetch port request; held high until i_ack.
REQ-006 i_addr  input  AW  fetch address.
REQ-007 i_rdata  output  DW  fetch read data; valid only when i_ack=1.
REQ-008 i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data port request (load/store); held high until d_ack.
REQ-010 d_addr  input  AW  data address.
REQ-011 d_wen  input  1  1 = store, 0 = load.
REQ-012 d_wdata  input  DW  store data.
REQ-013 d_strobe  input  DW/8  store byte enables.
REQ-014 d_rdata  output  DW  load data; valid only when d_ack=1.
REQ-015 d_ack  output  1  one-cycle data completion pulse.
REQ-016 m_req  output  1  shared memory port request.
REQ-017 m_addr, m_wen, m_wdata, m_strobe  output  AW/1/DW/(DW/8)  shared port transaction fields.
REQ-018 m_rdata  input  DW  shared port read data, valid with m_ack.
REQ-019 m_ack  input  1  shared port completion, one cycle, only while m_req=1.

Function
REQ-020 FSM states SHALL be IDLE, BUSY_I, BUSY_D; only one transaction outstanding.
REQ-021 IDLE, d_req=1, i_req=0 -> BUSY_D next cycle; i_req=1, d_req=0 -> BUSY_I.
REQ-022 IDLE, both requesting -> grant the port NOT served last (last_grant register, reset value I, so D wins first tie).
REQ-023 Grant edge SHALL latch the winner's addr/wen/wdata/strobe into holding registers; fetch grants latch m_wen=0, m_wdata=0, m_strobe=0.
REQ-024 m_req SHALL be 1 exactly in BUSY_I/BUSY_D; m_addr/m_wen/m_wdata/m_strobe driven from holding registers, stable until m_ack.
REQ-025 m_ack=1 in BUSY_x SHALL pulse x_ack combinationally in the same cycle, with x_rdata=m_rdata; state -> IDLE next cycle; last_grant updated to x.
REQ-026 Non-selected port's ack SHALL be 0 and its rdata SHALL be 0; both rdata outputs 0 when no ack.
REQ-027 Latency: request sampled in IDLE at cycle N -> m_req at N+1; with m_ack at N+1, x_ack at N+1; back-to-back grants separated by one IDLE cycle (max throughput one transaction per 2 cycles).
REQ-028 m_ack while IDLE SHALL be ignored (no ack pulse, no state change).
REQ-029 Requester dropping x_req mid-transaction SHALL NOT abort it; transaction completes on m_ack, ack pulse still issued and discarded by requester.
REQ-030 Inputs of the non-granted port SHALL be ignored while BUSY; its request remains pending and is arbitrated in the next IDLE.
REQ-031 No starvation: with both ports continuously requesting, grants SHALL alternate D, I, D, I...

Reset
REQ-032 reset=1 SHALL force state IDLE, last_grant=I, holding registers 0 on the next edge; m_req, i_ack, d_ack 0 from the cycle after the reset edge.
REQ-033 Reset during BUSY SHALL abandon the transaction: no ack pulse issued, late m_ack after reset ignored.
REQ-034 Reset dominates all other inputs in the same cycle.

Verification
REQ-035 Single fetch: i_req=1, i_addr=0x8000_0000, m_ack one cycle after m_req with m_rdata=0x13 -> m_addr=0x8000_0000, m_wen=0, i_ack pulse with i_rdata=0x13, d_ack stays 0.
REQ-036 Store: d_req=1, d_wen=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_strobe=0x0F, m_ack after 3 wait cycles -> m_* fields stable all 4 BUSY cycles, single d_ack pulse.
REQ-037 Simultaneous requests from reset, both held, m_ack immediate -> grant order D, I, D, I; acks spaced 2 cycles apart.
REQ-038 Fetch in BUSY_I while d_req rises mid-transaction -> d_addr changes ignored until IDLE, then D granted with then-current d_addr.
REQ-039 reset asserted in BUSY_D before m_ack, m_ack arrives next cycle -> no d_ack, m_req=0, state IDLE, next tie granted to D.
REQ-040 Spurious m_ack in IDLE -> no ack pulses, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between an instruction-fetch requester (i_*) and a
// load/store requester (d_*). Only one transaction is in flight at a time.
// When both ports request in the same idle cycle, the port that was not
// served last wins, so two ports that request continuously alternate.
//
// Parameters
//   AW        address width in bits
//   DW        data width in bits (DW/8 byte strobes)
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   i_req, i_addr               fetch request and address
//   i_rdata, i_ack              fetch read data and one-cycle completion pulse
//   d_req, d_addr, d_wen,       data request: address, store enable,
//   d_wdata, d_strobe           store data, byte enables
//   d_rdata, d_ack              load data and one-cycle completion pulse
//   m_req, m_addr, m_wen,       shared memory port request and transaction
//   m_wdata, m_strobe           fields, held stable until m_ack
//   m_rdata, m_ack              shared memory port read data and completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic [DW-1:0]     i_rdata,
    output logic              i_ack,

    input  logic              d_req,
    input  logic [AW-1:0]     d_addr,
    input  logic              d_wen,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_strobe,
    output logic [DW-1:0]     d_rdata,
    output logic              d_ack,

    output logic              m_req,
    output logic [AW-1:0]     m_addr,
    output logic              m_wen,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_strobe,
    input  logic [DW-1:0]     m_rdata,
    input  logic              m_ack
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t          state_q,       state_d;
    grant_t          last_grant_q,  last_grant_d;
    logic [AW-1:0]   hold_addr_q,   hold_addr_d;
    logic            hold_wen_q,    hold_wen_d;
    logic [DW-1:0]   hold_wdata_q,  hold_wdata_d;
    logic [SW-1:0]   hold_strobe_q, hold_strobe_d;

    // D wins when it is the only requester, or on a tie when I was served last.
    logic            pick_d;
    logic            pick_i;

    always_comb begin
        pick_d = d_req && (!i_req || (last_grant_q == GRANT_I));
        pick_i = i_req && !pick_d;
    end

    // Next-state, holding-register and completion logic.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        hold_addr_d   = hold_addr_q;
        hold_wen_d    = hold_wen_q;
        hold_wdata_d  = hold_wdata_q;
        hold_strobe_d = hold_strobe_q;
        i_ack         = 1'b0;
        d_ack         = 1'b0;
        i_rdata       = '0;
        d_rdata       = '0;

        unique case (state_q)
            IDLE: begin
                // m_ack while idle has no owner and is dropped.
                if (pick_d) begin
                    state_d       = BUSY_D;
                    hold_addr_d   = d_addr;
                    hold_wen_d    = d_wen;
                    hold_wdata_d  = d_wdata;
                    hold_strobe_d = d_strobe;
                end else if (pick_i) begin
                    state_d       = BUSY_I;
                    hold_addr_d   = i_addr;
                    hold_wen_d    = 1'b0;
                    hold_wdata_d  = '0;
                    hold_strobe_d = '0;
                end
            end

            BUSY_I: begin
                // Completes even if i_req has since dropped.
                if (m_ack) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_I;
                    i_ack        = !reset;
                    i_rdata      = reset ? '0 : m_rdata;
                end
            end

            BUSY_D: begin
                if (m_ack) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_D;
                    d_ack        = !reset;
                    d_rdata      = reset ? '0 : m_rdata;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A reset in the same cycle as m_ack abandons the transaction, so the
    // ack outputs above are also masked by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_I;
            hold_addr_q   <= '0;
            hold_wen_q    <= 1'b0;
            hold_wdata_q  <= '0;
            hold_strobe_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            hold_addr_q   <= hold_addr_d;
            hold_wen_q    <= hold_wen_d;
            hold_wdata_q  <= hold_wdata_d;
            hold_strobe_q <= hold_strobe_d;
        end
    end

    // Shared port is driven straight from the holding registers, so its
    // fields cannot move while a transaction is outstanding.
    always_comb begin
        m_req    = (state_q != IDLE);
        m_addr   = hold_addr_q;
        m_wen    = hold_wen_q;
        m_wdata  = hold_wdata_q;
        m_strobe = hold_strobe_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (one optional outstanding transaction record plus the port
// served last) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic            clk;
    logic            reset;
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_ack;
    logic            d_req;
    logic [AW-1:0]   d_addr;
    logic            d_wen;
    logic [DW-1:0]   d_wdata;
    logic [SW-1:0]   d_strobe;
    logic [DW-1:0]   d_rdata;
    logic            d_ack;
    logic            m_req;
    logic [AW-1:0]   m_addr;
    logic            m_wen;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_strobe;
    logic [DW-1:0]   m_rdata;
    logic            m_ack;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_wen    (d_wen),
        .d_wdata  (d_wdata),
        .d_strobe (d_strobe),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_wen    (m_wen),
        .m_wdata  (m_wdata),
        .m_strobe (m_strobe),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the outstanding transaction (if any) and who was last served.
    bit              mdl_busy;
    bit              mdl_port_d;
    bit              mdl_last_d;
    logic [AW-1:0]   mdl_addr;
    logic            mdl_wen;
    logic [DW-1:0]   mdl_wdata;
    logic [SW-1:0]   mdl_strobe;
    string           grants[$];
    int              ack_cycles[$];
    int              cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare all outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        logic exp_i_ack;
        logic exp_d_ack;
        @(negedge clk);
        exp_i_ack = !reset && mdl_busy && !mdl_port_d && m_ack;
        exp_d_ack = !reset && mdl_busy &&  mdl_port_d && m_ack;
        check("m_req",    m_req,    mdl_busy);
        check("m_addr",   m_addr,   mdl_addr);
        check("m_wen",    m_wen,    mdl_wen);
        check("m_wdata",  m_wdata,  mdl_wdata);
        check("m_strobe", m_strobe, mdl_strobe);
        check("i_ack",    i_ack,    exp_i_ack);
        check("d_ack",    d_ack,    exp_d_ack);
        check("i_rdata",  i_rdata,  exp_i_ack ? m_rdata : '0);
        check("d_rdata",  d_rdata,  exp_d_ack ? m_rdata : '0);
        if (exp_i_ack || exp_d_ack) ack_cycles.push_back(cyc);

        if (reset) begin
            mdl_busy = 0; mdl_last_d = 0;
            mdl_addr = '0; mdl_wen = 0; mdl_wdata = '0; mdl_strobe = '0;
        end else if (mdl_busy) begin
            if (m_ack) begin
                mdl_busy   = 0;
                mdl_last_d = mdl_port_d;
            end
        end else if (d_req && (!i_req || !mdl_last_d)) begin
            mdl_busy = 1; mdl_port_d = 1; grants.push_back("D");
            mdl_addr = d_addr; mdl_wen = d_wen; mdl_wdata = d_wdata; mdl_strobe = d_strobe;
        end else if (i_req) begin
            mdl_busy = 1; mdl_port_d = 0; grants.push_back("I");
            mdl_addr = i_addr; mdl_wen = 0; mdl_wdata = '0; mdl_strobe = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        string order;
        int    store_busy;
        cyc = 0;
        reset = 1; i_req = 0; i_addr = '0; d_req = 0; d_addr = '0; d_wen = 0;
        d_wdata = '0; d_strobe = '0; m_rdata = '0; m_ack = 0;
        mdl_busy = 0; mdl_port_d = 0; mdl_last_d = 0;
        mdl_addr = '0; mdl_wen = 0; mdl_wdata = '0; mdl_strobe = '0;
        @(posedge clk); #1;

        // Reset state
        step();
        check("reset_m_req", m_req, 1'b0);

        // Single fetch, m_ack one cycle after m_req
        reset = 0; i_req = 1; i_addr = 64'h8000_0000;
        step();
        m_ack = 1; m_rdata = 64'h13;
        #1;
        check("fetch_m_addr",  m_addr,  64'h8000_0000);
        check("fetch_m_wen",   m_wen,   1'b0);
        check("fetch_i_ack",   i_ack,   1'b1);
        check("fetch_i_rdata", i_rdata, 64'h13);
        check("fetch_d_ack",   d_ack,   1'b0);
        step();
        i_req = 0; m_ack = 0; m_rdata = '0;
        step();
        check("fetch_back_idle", m_req, 1'b0);

        // Store with 3 wait cycles
        d_req = 1; d_wen = 1; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF; d_strobe = 8'h0F;
        step();
        store_busy = 0;
        for (int k = 0; k < 4; k++) begin
            m_ack = (k == 3);
            m_rdata = 64'h5A5A;
            #1;
            if (m_req && m_addr == 64'h100 && m_wen && m_wdata == 64'hDEAD_BEEF && m_strobe == 8'h0F)
                store_busy++;
            step();
        end
        check("store_stable_cycles", store_busy, 4);
        d_req = 0; d_wen = 0; m_ack = 0;
        step();

        // Both requesting from reset, immediate m_ack: D, I, D, I
        reset = 1; step();
        reset = 0;
        grants.delete(); ack_cycles.delete();
        i_req = 1; i_addr = 64'h2000; d_req = 1; d_addr = 64'h3000; d_wen = 0;
        for (int k = 0; k < 8; k++) begin
            m_ack = m_req;
            m_rdata = 64'(k + 1);
            step();
        end
        m_ack = 0;
        order = "";
        for (int k = 0; k < 4; k++) order = {order, grants[k]};
        check("tie_order_DIDI", (order == "DIDI"), 1'b1);
        check("ack_spacing", ack_cycles[1] - ack_cycles[0], 2);
        i_req = 0; d_req = 0;
        step();

        // Fetch busy while d_req rises and d_addr wanders; D then gets current addr
        i_req = 1; i_addr = 64'h4000;
        step();
        d_req = 1; d_addr = 64'hAAA0; step();
        d_addr = 64'hBBB0; i_req = 0; step();
        d_addr = 64'hCCC0; m_ack = 1; m_rdata = 64'h77; step();
        m_ack = 0; step();
        check("late_d_addr", m_addr, 64'hCCC0);
        m_ack = 1; step();
        m_ack = 0; d_req = 0;

        // Reset in BUSY_D, late m_ack; next tie must go to D
        d_req = 1; d_addr = 64'h500; step();
        reset = 1; step();
        reset = 0; m_ack = 1; i_req = 1; i_addr = 64'h600;
        #1;
        check("rst_no_d_ack", d_ack, 1'b0);
        check("rst_m_req",    m_req, 1'b0);
        step();
        m_ack = 0;
        check("rst_tie_to_d", (grants[grants.size()-1] == "D"), 1'b1);
        m_ack = 1; step();
        m_ack = 0; i_req = 0; d_req = 0; step();
        step();

        // Spurious m_ack in IDLE
        m_ack = 1; m_rdata = 64'hFFFF;
        #1;
        check("spurious_i_ack", i_ack, 1'b0);
        check("spurious_d_ack", d_ack, 1'b0);
        step();
        m_ack = 0;
        check("spurious_state", m_req, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(99) < 2);
            if ($urandom_range(3) == 0) i_req = $urandom_range(1);
            if ($urandom_range(3) == 0) d_req = $urandom_range(1);
            i_addr   = {$urandom, $urandom};
            d_addr   = {$urandom, $urandom};
            d_wen    = $urandom_range(1);
            d_wdata  = {$urandom, $urandom};
            d_strobe = 8'($urandom);
            m_rdata  = {$urandom, $urandom};
            m_ack    = ($urandom_range(9) < 4);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
